// File: rtl/carry_select_adder_28b_adder_28b_2stage.sv
// 28-bit two-stage pipelined carry-select adder: stage 1 forms the low half and both
// high-half candidates, stage 2 picks the high candidate with the registered bit-13 carry.
module carry_select_adder_28b_adder_28b_2stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic [27:0] a,
  input  logic [27:0] b,
  input  logic        cin,
  output logic [28:0] sum
);

  // 14-bit carry-select adder built from 4-bit blocks; operands are zero-padded to 16 bits
  // so the carry out of bit 13 lands in bit 14 of the padded result.
  function automatic logic [14:0] csel14(input logic [13:0] x, input logic [13:0] y,
                                         input logic c);
    logic [15:0] xp;
    logic [15:0] yp;
    logic [15:0] r;
    logic [4:0]  s0;
    logic [4:0]  s1;
    logic        carry;
    xp    = {2'b00, x};
    yp    = {2'b00, y};
    r     = '0;
    carry = c;
    for (int unsigned blk = 0; blk < 4; blk++) begin
      s0 = {1'b0, xp[4*blk +: 4]} + {1'b0, yp[4*blk +: 4]};
      s1 = {1'b0, xp[4*blk +: 4]} + {1'b0, yp[4*blk +: 4]} + 5'd1;
      r[4*blk +: 4] = carry ? s1[3:0] : s0[3:0];
      carry         = carry ? s1[4]   : s0[4];
    end
    return r[14:0];
  endfunction

  logic [14:0] lo_full;
  logic [14:0] hi0_full;
  logic [14:0] hi1_full;

  always_comb begin
    lo_full  = csel14(a[13:0],  b[13:0],  cin);
    hi0_full = csel14(a[27:14], b[27:14], 1'b0);
    hi1_full = csel14(a[27:14], b[27:14], 1'b1);
  end

  logic [13:0] lo_q;
  logic        c13_q;
  logic [14:0] hi0_q;
  logic [14:0] hi1_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lo_q  <= '0;
      c13_q <= 1'b0;
      hi0_q <= '0;
      hi1_q <= '0;
      sum   <= '0;
    end else begin
      lo_q  <= lo_full[13:0];
      c13_q <= lo_full[14];
      hi0_q <= hi0_full;
      hi1_q <= hi1_full;
      sum   <= {(c13_q ? hi1_q : hi0_q), lo_q};
    end
  end

endmodule

// File: tb/tb_carry_select_adder_28b_adder_28b_2stage.sv
// Directed and streamed checks of the 2-stage 28-bit carry-select adder.
module tb_carry_select_adder_28b_adder_28b_2stage;

  logic        clk;
  logic        rstn;
  logic [27:0] a;
  logic [27:0] b;
  logic        cin;
  logic [28:0] sum;

  int total;
  int bad;

  carry_select_adder_28b_adder_28b_2stage dut (
    .clk  (clk),
    .rstn (rstn),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=hang expected=finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [28:0] obs, input logic [28:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_vec(input string tag, input logic [27:0] va, input logic [27:0] vb,
                         input logic vc, input logic [28:0] exp);
    a   = va;
    b   = vb;
    cin = vc;
    tick();
    tick();
    chk(tag, sum, exp);
  endtask

  logic [28:0] exp_q[$];
  logic [27:0] ra;
  logic [27:0] rb;

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    a     = 28'h1234567;
    b     = 28'h7654321;
    cin   = 1'b1;

    // held reset with live operands
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", sum, 29'h0);
      a = a + 28'h0111111;
    end

    #2;
    rstn = 1'b1;
    a    = '0;
    b    = '0;
    cin  = 1'b0;
    tick();
    chk("post_reset", sum, 29'h0);

    // latency: result must not appear after the capture edge
    a = 28'h0000001;
    b = 28'h0000002;
    tick();
    chk("latency_early", sum, 29'h0);
    tick();
    chk("latency", sum, 29'h0000003);

    run_vec("full_carry",   28'hFFFFFFF, 28'h0000001, 1'b0, 29'h10000000);
    run_vec("all_ones_cin", 28'hFFFFFFF, 28'hFFFFFFF, 1'b1, 29'h1FFFFFFF);
    run_vec("mid_b1",       28'h0003FFF, 28'h0000001, 1'b0, 29'h0004000);
    run_vec("mid_cin",      28'h0003FFF, 28'h0000000, 1'b1, 29'h0004000);
    run_vec("hi_only",      28'h1230000, 28'h0450000, 1'b0, 29'h1680000);
    run_vec("zeros_cin",    28'h0000000, 28'h0000000, 1'b1, 29'h0000001);

    // alternating slots
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        a = 28'hAAAAAAA;
        b = 28'h5555555;
      end else begin
        a = '0;
        b = '0;
      end
      cin = 1'b0;
      tick();
      if (i >= 1) chk("alternate", sum, ((i - 1) % 2 == 0) ? 29'h0FFFFFFF : 29'h0);
    end

    // random back-to-back stream
    exp_q.delete();
    for (int i = 0; i < 102; i++) begin
      if (i < 100) begin
        ra = 28'($urandom());
        rb = 28'($urandom());
      end else begin
        ra = '0;
        rb = '0;
      end
      a   = ra;
      b   = rb;
      cin = 1'b0;
      exp_q.push_back({1'b0, ra} + {1'b0, rb});
      tick();
      if (i >= 1) chk("stream", sum, exp_q.pop_front());
    end

    // mid-stream asynchronous reset
    run_vec("pre_abort", 28'h0ABCDEF, 28'h0111111, 1'b0, 29'h0BCDF00);
    a = 28'h7777777;
    b = 28'h1111111;
    tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset", sum, 29'h0);
    tick();
    chk("reset_held", sum, 29'h0);
    #2;
    rstn = 1'b1;
    a    = 28'h0000100;
    b    = 28'h0000023;
    cin  = 1'b1;
    tick();
    chk("refill_early", sum, 29'h0);
    tick();
    chk("refill", sum, 29'h0000124);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/carry_select_adder_28b_adder_28b_2stage.md
CARRY_SELECT_ADDER_28B_ADDER_28B_2STAGE -- requirements
Module: carry_select_adder_28b_adder_28b_2stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1 bit: the clock; all state updates occur on its rising edge.
REQ-004 Port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 Port a, input, 28 bits: first operand, unsigned.
REQ-006 Port b, input, 28 bits: second operand, unsigned.
REQ-007 Port cin, input, 1 bit: carry-in, added at bit 0.
REQ-008 Port sum, output, 29 bits: registered result; sum[28] is the carry-out.

Function
REQ-009 The block SHALL compute sum = a + b + cin, with 29-bit unsigned result and no overflow loss.
REQ-010 The block SHALL be a two-stage pipeline with no input register.
- Stage 1 register captures at rising edge k.
- Stage 2 (output) register captures at rising edge k+1.
REQ-011 Operands present at edge k SHALL appear on sum after edge k+1, giving a latency of 2 register stages.
REQ-012 Throughput SHALL be one new operand set per clock; back-to-back operands SHALL produce back-to-back results with no bubbles or stalls.
REQ-013 Stage 1 SHALL perform the low half (bits 13:0) using ripple/carry-select 4-bit-or-smaller blocks with cin, then register low sum[13:0] and the carry out of bit 13.
REQ-014 Stage 1 SHALL also compute the high half (bits 27:14) twice, once assuming carry-in 0 and once assuming carry-in 1.
REQ-015 Stage 1 SHALL register both high-half candidates, 15 bits each including carry-out.
REQ-016 Stage 2 SHALL select the high candidate using the registered bit-13 carry.
REQ-017 Stage 2 SHALL concatenate the selected high candidate with the registered low sum into the 29-bit output register.
REQ-018 Within each half, the block SHALL use carry-select sub-blocks: each sub-block computes both carry-in cases and a mux chain selects them; this carry-select structure is mandatory.
REQ-019 Boundary: a = b = 0x FFFFFFF with cin = 1 SHALL give sum = 0x1FFFFFFF.
REQ-020 Boundary: a = 0x0003FFF, b = 0, cin = 1 SHALL give sum = 0x0004000, with the carry propagating across the stage boundary.
REQ-021 The block SHALL contain no handshake, valid, or enable signals; the pipeline advances every clock.

Reset
REQ-022 While rstn = 0, all pipeline registers SHALL clear to 0 immediately, without waiting for a clock edge, and sum SHALL read 29'h0.
REQ-023 After rstn rises, the first two outputs SHALL reflect the reset contents plus any operands captured, with sum valid from the second rising edge after the first captured operands.
REQ-024 Assertion of reset mid-stream SHALL discard all in-flight results.
- sum SHALL read 0 until refilled.
- Refill SHALL follow the latency in REQ-011.

Verification
REQ-025 Reset: hold rstn = 0 with arbitrary a, b, and toggle clk -> sum = 0 throughout; then assert rstn = 0 asynchronously between edges mid-stream -> sum = 0 at once.
REQ-026 Latency: apply a = 0x0000001, b = 0x0000002, cin = 0 before edge k -> sum = 0x0000003 after edge k+1, and not after edge k.
REQ-027 Stream: apply 100 random operand pairs on consecutive cycles with cin = 0 -> each sum[i] matches the reference a[i] + b[i], two edges after capture, with zero mismatches.
REQ-028 Full carry: apply a = 0xFFFFFFF, b = 0x0000001, cin = 0 -> sum = 0x10000000; apply a = 0xFFFFFFF, b = 0xFFFFFFF, cin = 1 -> sum = 0x1FFFFFFF.
REQ-029 Mid-boundary carry: apply a = 0x0003FFF, b = 0x0000001, cin = 0 -> sum = 0x0004000; apply a = 0x0003FFF, b = 0, cin = 1 -> sum = 0x0004000.
REQ-030 Alternating operands: alternate the pair (0xAAAAAAA, 0x5555555) with the pair (0, 0) every cycle -> sum alternates 0x0FFFFFFF and 0, with no cross-contamination between pipeline slots.
